data_ram_hs: RTL and testbench
==============================

DATA_RAM_HS -- requirements
Module: data_ram_hs

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning byte-address width; capacity is 2**ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter INIT_FILE, default "ram.hex", meaning the hex image loaded at elaboration into 32-bit words; an empty string means no load.
Ports, one per line: name, direction, width, meaning.
REQ-003 The block SHALL have port clka, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1, the reset: asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, 1, request present.
REQ-006 The block SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are high at a clock edge.
REQ-007 The block SHALL have port req_addr, input, 32, byte address.
REQ-008 The block SHALL have port req_we, input, 1, write when 1, read when 0.
REQ-009 The block SHALL have port req_wdata, input, 32, store data, LSB-justified.
REQ-010 The block SHALL have port req_size, input, 3, access size: bit1 word, else bit0 half, else byte; bit2 unsigned (reads only).
REQ-011 The block SHALL have port resp_valid, output, 1, response present.
REQ-012 The block SHALL have port resp_ready, input, 1, response consumed when resp_valid and resp_ready are high at a clock edge.
REQ-013 The block SHALL have port resp_rdata, output, 32, load data, sign- or zero-extended; 0 for writes and errors.
REQ-014 The block SHALL have port resp_err, output, 1, out-of-range access.

Function
REQ-015 Storage SHALL be 2**(ADDR_WIDTH-2) 32-bit words with per-byte lane enables, little-endian.
REQ-016 FSM states SHALL be IDLE, ACC1 (second word of a split access) and RESP; req_ready = 1 only in IDLE.
REQ-017 On acceptance, an access whose bytes lie in one word SHALL complete in that cycle and enter RESP, so resp_valid rises the next cycle (latency 1).
REQ-018 An access crossing a word boundary SHALL handle the low word on the acceptance cycle, go to ACC1, handle the high word there and enter RESP (latency 2).
REQ-019 Request fields SHALL be registered at acceptance; later input changes SHALL not affect the access in flight.
REQ-020 An access is out of range if addr[31:ADDR_WIDTH] != 0 or its last byte exceeds 2**ADDR_WIDTH-1; no write occurs, resp_err=1, resp_rdata=0, latency 1, and there is no wrap-around.
REQ-021 Read data SHALL be extended from the accessed byte or half: sign-extended when bit2=0, zero-extended when bit2=1; words unchanged.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until handshake, then return to IDLE; no new request is accepted in the same cycle.
REQ-023 Writes SHALL produce a response with resp_rdata=0 and resp_err=0.

Reset
REQ-024 rstn low SHALL immediately force IDLE and resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 once rstn is high.
REQ-025 Reset SHALL not clear memory; a split write reset while in ACC1 leaves the low word written and the high word untouched.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding and the req_size field positions (WORD=1, HALF=0, UNS=2).
REQ-027 One sub-module, ram_lane_align, SHALL be combinational: it produces the byte-lane enables, shifted write data and extended read data from offset and size.

Verification
REQ-028 Write word 0x8899AABB @0x10, then lw @0x10 -> resp_rdata=0x8899AABB, latency 1 each.
REQ-029 With that data: lb @0x11 -> 0xFFFFFFAA; lbu @0x11 -> 0x000000AA; lh @0x12 -> 0xFFFF8899.
REQ-030 sw 0x11223344 @0x0E (split) -> latency 2; then lw @0x0C and @0x10 show bytes 0x44,0x33 at 0x0E,0x0F and 0x22,0x11 at 0x10,0x11.
REQ-031 lw @(2**ADDR_WIDTH-2) and sw @0x8000_0000 -> resp_err=1, rdata=0, memory unchanged.
REQ-032 Hold resp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout; rstn pulsed during ACC1 -> outputs zero at once and the low word is written.

Source files
------------

// File: rtl/data_ram_hs_pkg.sv
// Shared definitions for the handshaked byte-addressable data RAM.
package data_ram_hs_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC1 = 2'd1;  // high word of a word-crossing access
  localparam logic [1:0] ST_RESP = 2'd2;

  // req_size bit positions
  localparam int SZ_HALF = 0;
  localparam int SZ_WORD = 1;
  localparam int SZ_UNS  = 2;

  // Number of bytes touched by an access of the given size
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    if (size[SZ_WORD]) return 3'd4;
    if (size[SZ_HALF]) return 3'd2;
    return 3'd1;
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane steering over a two-word (64-bit) window: lane enables and
// shifted store data for writes, extracted and extended load data for reads.
module ram_lane_align
  import data_ram_hs_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  be,
  output logic [63:0] wdata64,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [31:0] raw;

  // Lane enables, store data placement and load extension
  always_comb begin
    mask    = size[SZ_WORD] ? 4'hF : (size[SZ_HALF] ? 4'h3 : 4'h1);
    be      = {4'b0, mask} << off;
    wdata64 = {32'b0, wdata} << {off, 3'b000};
    raw     = 32'(rword >> {off, 3'b000});
    if (size[SZ_WORD])
      rdata = raw;
    else if (size[SZ_HALF])
      rdata = size[SZ_UNS] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
    else
      rdata = size[SZ_UNS] ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
  end

endmodule

// File: rtl/data_ram_hs.sv
// Byte-addressable data RAM with valid/ready request and response channels.
// Accesses crossing a word boundary take an extra cycle for the high word.
module data_ram_hs
  import data_ram_hs_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = "ram.hex"
) (
  input  logic        clka,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int WI    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WI;

  logic [31:0] mem [DEPTH];

  logic [1:0]    state;
  logic [WI-1:0] widx_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          we_q;
  logic [31:0]   wdata_q, lo_q;

  logic          accept, err_c, split_c, in_acc1;
  logic [2:0]    nb, span;
  logic [32:0]   last;
  logic [WI-1:0] widx, widx_hi;
  logic [1:0]    a_off;
  logic [2:0]    a_size;
  logic [31:0]   a_wdata, rdata_al;
  logic [63:0]   a_rword, wdata64;
  logic [7:0]    be;

  assign req_ready  = rstn && (state == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == ST_RESP);
  assign in_acc1    = (state == ST_ACC1);

  // Range/split decode of the incoming request; in ACC1 the lane logic
  // works from the registered request so input changes cannot disturb it
  always_comb begin
    nb      = size_bytes(req_size);
    last    = {1'b0, req_addr} + {30'b0, nb} - 33'd1;
    err_c   = |last[32:ADDR_WIDTH];
    span    = {1'b0, req_addr[1:0]} + nb;
    split_c = span > 3'd4;
    widx    = in_acc1 ? widx_q  : req_addr[ADDR_WIDTH-1:2];
    widx_hi = widx + WI'(1);
    a_off   = in_acc1 ? off_q   : req_addr[1:0];
    a_size  = in_acc1 ? size_q  : req_size;
    a_wdata = in_acc1 ? wdata_q : req_wdata;
    a_rword = in_acc1 ? {mem[widx_hi], lo_q} : {mem[widx_hi], mem[widx]};
  end

  ram_lane_align u_align (
    .off     (a_off),
    .size    (a_size),
    .wdata   (a_wdata),
    .rword   (a_rword),
    .be      (be),
    .wdata64 (wdata64),
    .rdata   (rdata_al)
  );

  // Storage writes: low word on acceptance, high word in ACC1 (not reset)
  always_ff @(posedge clka) begin
    if (accept && req_we && !err_c)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdata64[8*i +: 8];
    if (in_acc1 && we_q)
      for (int i = 0; i < 4; i++)
        if (be[4+i]) mem[widx_hi][8*i +: 8] <= wdata64[32+8*i +: 8];
  end

  // Control FSM, request capture and response registers
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      widx_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          widx_q  <= req_addr[ADDR_WIDTH-1:2];
          off_q   <= req_addr[1:0];
          size_q  <= req_size;
          we_q    <= req_we;
          wdata_q <= req_wdata;
          lo_q    <= mem[widx];
          if (err_c) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= ST_RESP;
          end else if (split_c) begin
            state <= ST_ACC1;
          end else begin
            resp_rdata <= req_we ? '0 : rdata_al;
            resp_err   <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_ACC1: begin
          resp_rdata <= we_q ? '0 : rdata_al;
          resp_err   <= 1'b0;
          state      <= ST_RESP;
        end
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_hs.sv
// Randomized self-checking bench for data_ram_hs against a byte-array model.
module tb_data_ram_hs;

  localparam int AW   = 10;
  localparam int SIZE = 2 ** AW;

  logic        clka = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_size;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_m [SIZE];

  always #5 clka = ~clka;

  data_ram_hs #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
    .clka(clka), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // One transaction: model expectation, drive, measure latency, hold, consume
  task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                      input logic [2:0] size, input int hold);
    int          nb;
    longint      lastb;
    bit          oob;
    int          elat, lat;
    logic [31:0] raw, erd;
    nb    = size[1] ? 4 : (size[0] ? 2 : 1);
    lastb = longint'(addr) + nb - 1;
    oob   = lastb > SIZE - 1;
    elat  = oob ? 1 : ((int'(addr % 4) + nb > 4) ? 2 : 1);
    erd   = '0;
    raw   = '0;
    if (!oob) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) raw[8*i +: 8] = mem_m[int'(addr) + i];
        if (nb == 4)      erd = raw;
        else if (nb == 2) erd = size[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        else              erd = size[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      end
    end
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_addr = addr; req_we = we; req_wdata = wd; req_size = size;
    @(posedge clka); #1;
    req_valid = 0; req_addr = $urandom; req_we = 1'($urandom);
    req_wdata = $urandom; req_size = 3'($urandom);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clka); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("rdata", resp_rdata, erd);
    chk("err", resp_err, oob);
    for (int h = 0; h < hold; h++) begin
      @(posedge clka); #1;
      chk("hold", {resp_valid, req_ready, resp_err, resp_rdata}, {1'b1, 1'b0, oob, erd});
    end
    resp_ready = 1;
    @(posedge clka); #1;
    resp_ready = 0;
    chk("resp_drop", resp_valid, 0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    rstn = 0; req_valid = 0; req_addr = 0; req_we = 0; req_wdata = 0;
    req_size = 0; resp_ready = 0;
    repeat (2) @(posedge clka);
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    rstn = 1;
    #1;
    chk("rst_ready", req_ready, 1);

    // Fill memory so model and RAM start identical
    for (int w = 0; w < SIZE / 4; w++) xact(32'(w * 4), 1, $urandom, 3'b010, 0);

    // Directed cases
    xact(32'h10, 1, 32'h8899AABB, 3'b010, 0);
    xact(32'h10, 0, 0, 3'b010, 0);
    chk("lw10_const", resp_rdata, 32'h8899AABB);
    xact(32'h11, 0, 0, 3'b000, 0);
    chk("lb11_const", resp_rdata, 32'hFFFFFFAA);
    xact(32'h11, 0, 0, 3'b100, 0);
    chk("lbu11_const", resp_rdata, 32'h000000AA);
    xact(32'h12, 0, 0, 3'b001, 0);
    chk("lh12_const", resp_rdata, 32'hFFFF8899);
    xact(32'h0E, 1, 32'h11223344, 3'b010, 0);
    xact(32'h0C, 0, 0, 3'b010, 0);
    chk("lw0c_hi", resp_rdata[31:16], 16'h3344);
    xact(32'h10, 0, 0, 3'b010, 0);
    chk("lw10_split", resp_rdata, 32'h88991122);
    xact(32'(SIZE - 2), 0, 0, 3'b010, 0);
    xact(32'h8000_0000, 1, 32'hCAFEF00D, 3'b010, 0);
    xact(32'(SIZE - 4), 1, 32'h01020304, 3'b001, 0);
    xact(32'h0, 0, 0, 3'b010, 5);
    xact(32'(SIZE - 4), 0, 0, 3'b010, 0);

    // Reset while the high word of a split write is pending
    chk("rdy_pre_acc1", req_ready, 1);
    req_valid = 1; req_addr = 32'h20E; req_we = 1; req_wdata = 32'hDEADBEEF; req_size = 3'b010;
    @(posedge clka); #1;
    req_valid = 0;
    chk("acc1_no_valid", resp_valid, 0);
    rstn = 0;
    #1;
    chk("acc1_rst_valid", resp_valid, 0);
    chk("acc1_rst_rdata", resp_rdata, 0);
    chk("acc1_rst_err", resp_err, 0);
    mem_m[32'h20E] = 8'hEF;
    mem_m[32'h20F] = 8'hBE;
    @(posedge clka); #1;
    rstn = 1;
    #1;
    chk("acc1_rst_ready", req_ready, 1);
    xact(32'h20C, 0, 0, 3'b010, 0);
    xact(32'h210, 0, 0, 3'b010, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, SIZE - 1));
      else if (r < 9) a = 32'($urandom_range(SIZE - 8, SIZE - 1));
      else            a = $urandom;
      xact(a, 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
           $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
